// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode codes and the pattern next-value function shared by generator, decoder and bench.
package led_pattern_pkg;
  localparam logic [2:0] MODE_ROT_L  = 3'd0;
  localparam logic [2:0] MODE_ROT_R  = 3'd1;
  localparam logic [2:0] MODE_CNT_UP = 3'd2;
  localparam logic [2:0] MODE_CNT_DN = 3'd3;
  localparam logic [2:0] MODE_BLINK  = 3'd4;
  localparam logic [2:0] MODE_FILL   = 3'd5;
  localparam int N_MODES = 6;
  function automatic logic [4:0] next_pattern(input logic [2:0] mode, input logic [4:0] q);
    return mode == MODE_ROT_L  ? {q[3:0], q[4]} :
           mode == MODE_ROT_R  ? {q[0], q[4:1]} :
           mode == MODE_CNT_UP ? q + 5'd1 :
           mode == MODE_CNT_DN ? q - 5'd1 :
           mode == MODE_BLINK  ? ~q :
           mode == MODE_FILL   ? (&q ? 5'd0 : {q[3:0], 1'b1}) : q;
  endfunction
endpackage

// File: rtl/led_mode_match_cnt.sv
// led_mode_match_cnt: saturating count of consecutive transitions that fit one mode.
module led_mode_match_cnt #(
  parameter int LOCK_COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ev,
  input  logic match,
  input  logic clr,
  output logic sat
);
  logic [2:0] cnt;
  assign sat = cnt == 3'(LOCK_COUNT);
  always_ff @(posedge clk)
    if (rst || clr || (ev && !match)) cnt <= '0;
    else if (ev && !sat) cnt <= cnt + 3'd1;
endmodule

// File: rtl/led_pattern_decoder.sv
// led_pattern_decoder: recovers the running pattern mode from the LED bus and flags stalls and illegal steps.
module led_pattern_decoder
  import led_pattern_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 50_000_000
) (
  input  logic       CLK50MHz,
  input  logic       RST,
  input  logic [4:0] Q_IN,
  output logic [2:0] MODE,
  output logic       LOCKED,
  output logic       STALL,
  output logic       ILLEGAL
);
  localparam int IW = $clog2(TIMEOUT);
  logic               primed;
  logic [4:0]         q_prev;
  logic [IW-1:0]      idle;
  logic               ev;
  logic               stall_hit;
  logic [N_MODES-1:0] match;
  logic [N_MODES-1:0] sat;
  logic [2:0]         first;
  assign ev        = primed && Q_IN != q_prev;
  assign stall_hit = primed && !ev && idle == IW'(TIMEOUT - 1);
  for (genvar m = 0; m < N_MODES; m++) begin : g_mode
    assign match[m] = next_pattern(3'(m), q_prev) == Q_IN;
    led_mode_match_cnt #(.LOCK_COUNT(LOCK_COUNT)) u_cnt (
      .clk(CLK50MHz), .rst(RST), .ev(ev), .match(match[m]), .clr(stall_hit), .sat(sat[m])
    );
  end
  // lowest saturated index wins when a step fits several modes
  always_comb begin
    first = '0;
    for (int i = N_MODES - 1; i >= 0; i--) if (sat[i]) first = 3'(i);
  end
  always_ff @(posedge CLK50MHz)
    if (RST) begin
      primed  <= 1'b0;
      q_prev  <= '0;
      idle    <= '0;
      MODE    <= '0;
      LOCKED  <= 1'b0;
      STALL   <= 1'b0;
      ILLEGAL <= 1'b0;
    end else begin
      primed  <= 1'b1;
      ILLEGAL <= ev && !(|match);
      LOCKED  <= |sat;
      MODE    <= |sat ? first : MODE;
      if (!primed || ev) q_prev <= Q_IN;
      if (ev) begin
        idle  <= '0;
        STALL <= 1'b0;
      end else if (stall_hit) STALL <= 1'b1;
      else if (primed) idle <= idle + IW'(1);
    end
endmodule

// File: tb/tb_led_pattern_decoder.sv
// tb_led_pattern_decoder: directed checks of locking, ambiguity, illegal steps, stall and reset.
module tb_led_pattern_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] q_in = '0;
  logic [2:0] mode;
  logic       locked, stall, illegal;
  int         checks = 0;
  int         fails = 0;

  led_pattern_decoder #(.LOCK_COUNT(4), .TIMEOUT(20)) dut (
    .CLK50MHz(clk), .RST(rst), .Q_IN(q_in),
    .MODE(mode), .LOCKED(locked), .STALL(stall), .ILLEGAL(illegal)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [4:0] v, input int hold);
    q_in = v;
    cyc();
    repeat (hold) cyc();
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [4:0] v);
    rst = 1'b1;
    q_in = v;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst = 1'b1;
    q_in = 5'd3;
    cyc();
    chk("rst_mode", 5'(mode), 5'd0);
    chk("rst_locked", 5'(locked), 5'd0);
    chk("rst_stall", 5'(stall), 5'd0);
    chk("rst_illegal", 5'(illegal), 5'd0);
    rst = 1'b0;
    cyc();
    // CNT_UP 3..7, one step every 8 clocks
    for (int v = 4; v <= 7; v++) begin
      q_in = 5'(v);
      cyc();
      chk("cntup_illegal", 5'(illegal), 5'd0);
      cyc();
      chk("cntup_locked", 5'(locked), (v == 7) ? 5'd1 : 5'd0);
      repeat (6) cyc();
    end
    chk("cntup_mode", 5'(mode), 5'd2);
    // ROT_L vs CNT_UP ambiguity
    do_reset(5'd1);
    step(5'd2, 2);
    step(5'd4, 2);
    step(5'd8, 2);
    chk("amb_prelock", 5'(locked), 5'd0);
    step(5'd16, 1);
    chk("amb_locked", 5'(locked), 5'd1);
    chk("amb_mode", 5'(mode), 5'd0);
    step(5'd1, 1);
    chk("amb_hold_mode", 5'(mode), 5'd0);
    chk("amb_hold_locked", 5'(locked), 5'd1);
    // BLINK vs FILL/CNT_UP/CNT_DN
    do_reset(5'd31);
    step(5'd0, 1);
    step(5'd31, 1);
    step(5'd0, 1);
    step(5'd31, 0);
    chk("blink_prelock", 5'(locked), 5'd0);
    cyc();
    chk("blink_locked", 5'(locked), 5'd1);
    chk("blink_mode", 5'(mode), 5'd4);
    // lock on CNT_DN, then illegal step
    do_reset(5'd20);
    step(5'd19, 1);
    step(5'd18, 1);
    step(5'd17, 1);
    step(5'd16, 1);
    chk("dn_locked", 5'(locked), 5'd1);
    chk("dn_mode", 5'(mode), 5'd3);
    step(5'd9, 0);
    chk("ill_pulse", 5'(illegal), 5'd1);
    chk("ill_locked_still", 5'(locked), 5'd1);
    cyc();
    chk("ill_pulse_end", 5'(illegal), 5'd0);
    chk("ill_unlocked", 5'(locked), 5'd0);
    chk("ill_mode_held", 5'(mode), 5'd3);
    step(5'd22, 0);
    chk("ill_blink_legal", 5'(illegal), 5'd0);
    chk("ill_mode_held2", 5'(mode), 5'd3);
    // ROT_R lock, then stall
    do_reset(5'd1);
    step(5'd16, 1);
    step(5'd8, 1);
    step(5'd4, 1);
    step(5'd2, 0);
    cyc();
    chk("rotr_locked", 5'(locked), 5'd1);
    chk("rotr_mode", 5'(mode), 5'd1);
    repeat (18) cyc();
    chk("stall_early", 5'(stall), 5'd0);
    cyc();
    chk("stall_set", 5'(stall), 5'd1);
    chk("stall_locked_still", 5'(locked), 5'd1);
    cyc();
    chk("stall_unlocked", 5'(locked), 5'd0);
    chk("stall_held", 5'(stall), 5'd1);
    step(5'd1, 0);
    chk("stall_clear", 5'(stall), 5'd0);
    chk("stall_legal", 5'(illegal), 5'd0);
    step(5'd16, 1);
    step(5'd8, 1);
    chk("restart_prelock", 5'(locked), 5'd0);
    step(5'd4, 1);
    chk("restart_locked", 5'(locked), 5'd1);
    chk("restart_mode", 5'(mode), 5'd1);
    // reset while locked
    rst = 1'b1;
    cyc();
    chk("midrst_locked", 5'(locked), 5'd0);
    chk("midrst_mode", 5'(mode), 5'd0);
    chk("midrst_stall", 5'(stall), 5'd0);
    rst = 1'b0;
    cyc();
    step(5'd2, 1);
    step(5'd1, 1);
    step(5'd16, 1);
    chk("midrst_prelock", 5'(locked), 5'd0);
    step(5'd8, 1);
    chk("midrst_relock", 5'(locked), 5'd1);
    chk("midrst_mode2", 5'(mode), 5'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/led_pattern_decoder.md
Name: led_pattern_decoder

Overview:
- Observes the 5-bit LED pattern bus Q driven by the pattern generator and recovers which of the six pattern modes is running, as the S2..S0 select code.
- It is the decoder that pairs with the S-select-to-Q encoder. It sits beside the generator on the 50 MHz board clock and feeds self-check and status logic.
- It flags stalls (no pattern activity) and illegal transitions.

Parameters:
- LOCK_COUNT, 4: consecutive matching transitions required before a mode is reported (legal range 2..7).
- TIMEOUT, 50_000_000: idle clocks with no change on Q_IN before a stall is declared. Benches override it to a small value.

Ports:
- CLK50MHz  in  1  system clock, 50 MHz
- RST  in  1  reset, synchronous, active-high
- Q_IN  in  5  observed LED pattern, same clock domain as CLK50MHz
- MODE  out  3  decoded select code {S2,S1,S0}; valid only while LOCKED=1
- LOCKED  out  1  a mode has met LOCK_COUNT
- STALL  out  1  no change on Q_IN for TIMEOUT clocks
- ILLEGAL  out  1  one-cycle pulse when a transition matches no mode

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: on a rising CLK50MHz edge with RST=1, every register clears.
  - After reset: MODE=0, LOCKED=0, STALL=0, ILLEGAL=0, primed=0, q_prev=0, all match counters=0, idle counter=0.
- Mode set. Next-value function for q_prev, in 5-bit arithmetic, wrapping mod 32:
  - 0 ROT_L: {q[3:0],q[4]}
  - 1 ROT_R: {q[0],q[4:1]}
  - 2 CNT_UP: q+1
  - 3 CNT_DN: q-1
  - 4 BLINK: ~q
  - 5 FILL: 5'b11111 goes to 0; otherwise {q[3:0],1'b1}
  - Codes 6 and 7 are never output.
- Priming:
  - First edge after reset with primed=0: q_prev<=Q_IN, primed<=1, no evaluation.
- Transition event: primed=1 and Q_IN!=q_prev. On that edge:
  - q_prev<=Q_IN and idle counter<=0.
  - For each mode m: if next_m(q_prev)==Q_IN, cnt[m] increments, saturating at LOCK_COUNT; otherwise cnt[m]<=0.
  - If no mode matches, ILLEGAL pulses high for exactly the next cycle.
- Output register. Updated every edge from the counter values of the previous edge, so there is one clock of latency after the qualifying transition.
  - LOCKED = any cnt[m]==LOCK_COUNT.
  - MODE = lowest index m with cnt[m]==LOCK_COUNT. This resolves ambiguity, e.g. 00001->00010 fits both ROT_L and CNT_UP.
  - When LOCKED=0, MODE holds its last value.
- Stall:
  - With no transition, the idle counter increments. On reaching TIMEOUT-1, all cnt<=0 and STALL<=1; LOCKED falls on the following cycle.
  - The idle counter saturates. STALL clears on the next transition edge, and that transition is evaluated normally.
- Mode change mid-stream:
  - The old mode's counter zeroes on its first mismatching transition, so LOCKED drops one cycle later.
  - The new mode locks after LOCK_COUNT matches. Its counter already counts from the first transition into the new pattern, if that transition matches.
- Reset mid-operation: takes priority over every event on the same edge. Priming restarts.
- Q_IN unchanged: never counts as a transition. Static patterns, including 00000 under rotate, only advance the idle counter.

Decomposition:
- Shared package led_pattern_pkg holds:
  - the mode code constants MODE_ROT_L=0 … MODE_FILL=5 and N_MODES=6;
  - a function next_pattern(mode, q) that is also used by the generator and the bench model.
- One natural sub-module, led_mode_match_cnt: a single mode's saturating match counter. It is instantiated six times.

Test Plan:
- CNT_UP: reset, then Q_IN steps 3,4,5,6,7, one transition every 8 clocks -> LOCKED=1 and MODE=2 one clock after the transition to 7; ILLEGAL never pulses.
- Ambiguity: Q_IN steps 00001,00010,00100,01000,10000,00001 -> ROT_L counter saturates while CNT_UP resets at 2->4 -> MODE=0, LOCKED=1.
- BLINK vs FILL: Q_IN alternates 11111,00000,11111,00000,11111 -> BLINK (4) reaches LOCK_COUNT; FILL resets at 00000->11111 -> MODE=4.
- Illegal transition: locked on CNT_DN (MODE=3), inject 9 then 22 -> ILLEGAL high for one cycle, LOCKED=0 one clock later, MODE still 3.
- Stall: TIMEOUT=20, locked on ROT_R, hold Q_IN constant -> STALL=1 after 20 idle clocks and LOCKED=0 on the next clock. One legal transition -> STALL=0, counters restart from 1.
- Reset mid-lock: assert RST for one edge while LOCKED=1 -> all outputs 0 the next cycle. The first following edge only primes; no lock until LOCK_COUNT further transitions.
